or_gate_n_collector: RTL
========================

Name: or_gate_n_collector

Overview:
- Parametrised successor to the fixed 3-input OR gate with bubble inversion: NUM_INPUTS inputs of WIDTH bits, each with optional per-input inversion via BubblesMask, reduced by bitwise OR.
- Adds a registered result stage with four modes: pass, sticky accumulate, rising-edge detect and hold.
- Reports the lowest contributing input index and keeps a saturating event counter.
- Serves as the CPU's fault/interrupt-request collector, e.g. gathering exception sources into a sticky cause word.

Parameters:
- NUM_INPUTS, 3, number of input channels (2..16).
- WIDTH, 1, bits per channel.
- BubblesMask, 0, NUM_INPUTS bits; bit i set inverts every bit of input i before the OR.
- CNT_WIDTH, 8, width of EventCount.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high; clears all state regardless of Tick.
- Tick  input  1  clock enable; state updates only on Clock edges with Tick=1.
- Mode  input  2  00 PASS, 01 STICKY, 10 EDGE, 11 HOLD.
- Clear  input  1  synchronous clear of Result/Src/count; qualified by Tick.
- Inputs  input  NUM_INPUTS*WIDTH  input i at bits [i*WIDTH +: WIDTH].
- Result  output  WIDTH  registered collected vector.
- Any  output  1  combinational |Result.
- SrcIdx  output  clog2(NUM_INPUTS) (min 1)  lowest contributing input index.
- SrcValid  output  1  SrcIdx meaningful.
- EventCount  output  CNT_WIDTH  saturating count of active Ticks.

Behaviour:
- Reset (edge with Reset=1): Result=0, SrcIdx=0, SrcValid=0, EventCount=0, internal prev=0. Reset has priority over Tick and Clear, and is legal at any time, including mid-accumulation.
- Combinational terms:
  - real_i = input_i ^ {WIDTH{BubblesMask[i]}}.
  - s_or = OR over all real_i.
  - s_edge = s_or & ~prev.
  - s_new = s_or in PASS/STICKY; s_edge in EDGE.
- prev register: prev <= s_or on every Tick, in all modes, including Clear and HOLD.
- Tick=0: all registers hold.
- Tick=1, Clear=1: Result=0, SrcValid=0, SrcIdx=0, EventCount=0. Clear wins over STICKY; that cycle's inputs are discarded.
- Tick=1, Clear=0, per mode:
  - PASS: Result <= s_or. Latency is one Tick.
  - STICKY: Result <= Result | s_or.
  - EDGE: Result <= s_edge, a one-Tick pulse per newly set bit.
  - HOLD: Result, SrcIdx, SrcValid and EventCount unchanged.
- Source index:
  - cand = lowest i with (real_i & s_new) != 0; candvalid = (s_new != 0).
  - PASS/EDGE: SrcIdx <= cand (0 if none); SrcValid <= candvalid.
  - STICKY: if SrcValid=0 and candvalid, latch cand and set SrcValid. Once valid, SrcIdx stays as the first source until Clear/Reset.
- EventCount: +1 when Tick=1, Clear=0, Mode!=HOLD and s_new!=0. Saturates at all-ones; no wrap.
- Mode change: Result keeps its value; the new mode applies from the next Tick. Entering STICKY from PASS accumulates onto the existing Result.
- Bubble note: with BubblesMask!=0 and all inputs 0, s_or is nonzero. EDGE therefore reports a rise on the first Tick after Reset.
- No combinational path from Inputs to any output.

Test Plan:
- NUM_INPUTS=3, WIDTH=4, BubblesMask=0, PASS: in0=4'h1, in1=4'h4, in2=0, one Tick -> Result=4'h5, Any=1, SrcIdx=0, SrcValid=1, EventCount=1. All inputs 0 next Tick -> Result=0, SrcValid=0, EventCount=1.
- BubblesMask=3'b100, PASS, all inputs 0 -> Result=4'hF, SrcIdx=2. Then in2=4'hF -> Result=0, SrcValid=0.
- STICKY, s_or sequence 4'h1 (from in0), 4'h8 (from in1), 0 -> Result 1, 9, 9; SrcIdx stays 0; EventCount=2. Then Clear=1 with in1=4'h2 -> Result=0, SrcValid=0, EventCount=0.
- EDGE, s_or sequence 3, 3, 7, 0, 7 -> Result 3, 0, 4, 0, 7; EventCount=3.
- Inputs toggling with Tick=0 -> no register changes. Then HOLD with Tick=1 -> Result/count frozen, but prev tracks s_or: a following EDGE Tick with unchanged s_or gives Result=0.
- CNT_WIDTH=2, PASS, 5 nonzero Ticks -> EventCount=3 (saturated). Reset asserted with Tick=0 mid-STICKY -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/or_gate_n_collector_if.sv
// Bundle of the collector's control, input and status signals.
//   master : drives Tick/Mode/Clear/Inputs, observes the collected status
//   slave  : the collector itself
// Tick       clock enable for every register in the collector
// Mode       00 PASS, 01 STICKY, 10 EDGE, 11 HOLD
// Clear      synchronous clear of Result/SrcIdx/SrcValid/EventCount (Tick-qualified)
// Inputs     NUM_INPUTS channels, channel i at [i*WIDTH +: WIDTH]
// Result     registered collected vector
// Any        |Result
// SrcIdx     lowest contributing channel index, SrcValid qualifies it
// EventCount saturating count of contributing Ticks
interface or_gate_n_collector_if #(
  parameter int unsigned NUM_INPUTS = 3,
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned CNT_WIDTH  = 8
);
  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                        Tick;
  logic [1:0]                  Mode;
  logic                        Clear;
  logic [NUM_INPUTS*WIDTH-1:0] Inputs;
  logic [WIDTH-1:0]            Result;
  logic                        Any;
  logic [IDX_W-1:0]            SrcIdx;
  logic                        SrcValid;
  logic [CNT_WIDTH-1:0]        EventCount;

  modport master (
    output Tick, Mode, Clear, Inputs,
    input  Result, Any, SrcIdx, SrcValid, EventCount
  );

  modport slave (
    input  Tick, Mode, Clear, Inputs,
    output Result, Any, SrcIdx, SrcValid, EventCount
  );
endinterface

// File: rtl/or_gate_n_collector.sv
// Fault / interrupt-request collector: NUM_INPUTS channels of WIDTH bits,
// each optionally inverted (BubblesMask), ORed together and captured into a
// registered Result in one of four modes (PASS, STICKY, EDGE, HOLD).
// Also reports the lowest contributing channel and a saturating event count.
// Ports:
//   Clock  rising-edge clock
//   Reset  synchronous active-high reset, overrides Tick and Clear
//   bus    slave side of or_gate_n_collector_if (see that file)
// All outputs come from registers; Any is a reduction of registered Result.
module or_gate_n_collector #(
  parameter int unsigned          NUM_INPUTS  = 3,
  parameter int unsigned          WIDTH       = 1,
  parameter logic [NUM_INPUTS-1:0] BubblesMask = '0,
  parameter int unsigned          CNT_WIDTH   = 8
) (
  input logic                  Clock,
  input logic                  Reset,
  or_gate_n_collector_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_STICKY = 2'b01,
    MODE_EDGE   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [WIDTH-1:0]     result_q,    result_d;
  logic [IDX_W-1:0]     src_idx_q,   src_idx_d;
  logic                 src_valid_q, src_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0]     prev_q,      prev_d;

  mode_e            mode;
  logic [WIDTH-1:0] real_v [NUM_INPUTS];
  logic [WIDTH-1:0] s_or;
  logic [WIDTH-1:0] s_edge;
  logic [WIDTH-1:0] s_new;
  logic [IDX_W-1:0] cand;
  logic             cand_valid;
  logic             cand_found;

  always_comb begin
    mode = mode_e'(bus.Mode);
    s_or = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      real_v[i] = bus.Inputs[i*WIDTH +: WIDTH] ^ {WIDTH{BubblesMask[i]}};
      s_or      = s_or | real_v[i];
    end
    s_edge = s_or & ~prev_q;
    s_new  = (mode == MODE_EDGE) ? s_edge : s_or;

    // Source is judged against s_new, so in EDGE mode only channels that
    // contributed a newly risen bit qualify.
    cand       = '0;
    cand_found = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (!cand_found && ((real_v[i] & s_new) != '0)) begin
        cand       = IDX_W'(i);
        cand_found = 1'b1;
      end
    end
    cand_valid = (s_new != '0);
  end

  always_comb begin
    result_d    = result_q;
    src_idx_d   = src_idx_q;
    src_valid_d = src_valid_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;

    if (bus.Tick) begin
      // prev tracks s_or in every mode so EDGE after HOLD/Clear sees the
      // true history rather than a stale value.
      prev_d = s_or;
      if (bus.Clear) begin
        result_d    = '0;
        src_idx_d   = '0;
        src_valid_d = 1'b0;
        cnt_d       = '0;
      end else if (mode != MODE_HOLD) begin
        unique case (mode)
          MODE_PASS: begin
            result_d    = s_or;
            src_idx_d   = cand;
            src_valid_d = cand_valid;
          end
          MODE_STICKY: begin
            result_d = result_q | s_or;
            if (!src_valid_q && cand_valid) begin
              src_idx_d   = cand;
              src_valid_d = 1'b1;
            end
          end
          MODE_EDGE: begin
            result_d    = s_edge;
            src_idx_d   = cand;
            src_valid_d = cand_valid;
          end
          default: ;
        endcase
        if (cand_valid && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      result_q    <= '0;
      src_idx_q   <= '0;
      src_valid_q <= 1'b0;
      cnt_q       <= '0;
      prev_q      <= '0;
    end else begin
      result_q    <= result_d;
      src_idx_q   <= src_idx_d;
      src_valid_q <= src_valid_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
    end
  end

  assign bus.Result     = result_q;
  assign bus.Any        = |result_q;
  assign bus.SrcIdx     = src_idx_q;
  assign bus.SrcValid   = src_valid_q;
  assign bus.EventCount = cnt_q;
endmodule
